// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: FSM states, command codes, reply bytes
// and frame checksum. Used by the RTL and by the bench's frame builder.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StData,
        StCsum,
        StExec,
        StResp
    } state_e;

    localparam logic [7:0] CMD_FTW  = 8'h01;
    localparam logic [7:0] CMD_WAVE = 8'h02;
    localparam logic [7:0] CMD_AMP  = 8'h03;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam int unsigned FRAME_LEN = 7;

    function automatic logic [7:0] frame_csum(input logic [7:0] cmd, input logic [31:0] data);
        return cmd ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
    endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter for the command parser; clears on request, saturates at
// TIMEOUT_CYC-1 and flags expiry. Only used when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_timer #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned TIMEOUT_BIT = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_BIT-1:0] LAST_CNT = TIMEOUT_BIT'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_BIT-1:0] cnt_q;

    assign expired = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + TIMEOUT_BIT'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes 7-byte command frames from the uart RX FIFO into DDS control registers and
// replies ACK/NAK via the TX FIFO. Define UART_CMD_TIMEOUT_EN for the inter-byte timeout.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [31:0] FTW_RST     = 32'd0,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned TIMEOUT_BIT = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    input  logic        tx_full,
    output logic        wr_uart,
    output logic [7:0]  w_data,
    output logic [31:0] ftw,
    output logic        ftw_upd,
    output logic [1:0]  wave_sel,
    output logic [7:0]  amp,
    output logic        timeout_err
);

    state_e      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  reply_q, reply_d;
    logic [31:0] ftw_q, ftw_d;
    logic        ftw_upd_q, ftw_upd_d;
    logic [1:0]  wave_q, wave_d;
    logic [7:0]  amp_q, amp_d;
    logic        pop_block_q;
    logic        consume, pop, timeout_hit;

    assign consume = (state_q == StIdle) || (state_q == StCmd) ||
                     (state_q == StData) || (state_q == StCsum);
    // Blocking the cycle after a pop gives the FIFO time to present its next head.
    assign pop     = consume && !rx_empty && !pop_block_q;
    assign rd_uart = pop;

`ifdef UART_CMD_TIMEOUT_EN
    logic counting, expired;

    assign counting = (state_q == StCmd) || (state_q == StData) || (state_q == StCsum);

    uart_cmd_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TIMEOUT_BIT(TIMEOUT_BIT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (pop || !counting),
        .enable (counting),
        .expired(expired)
    );

    assign timeout_hit = counting && !pop && expired;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYC, TIMEOUT_BIT};
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        reply_d   = reply_q;
        ftw_d     = ftw_q;
        ftw_upd_d = 1'b0;
        wave_d    = wave_q;
        amp_d     = amp_q;
        wr_uart   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pop && r_data == SYNC_BYTE) state_d = StCmd;
            end
            StCmd: begin
                if (pop) begin
                    cmd_d   = r_data;
                    cnt_d   = 2'd3;
                    state_d = StData;
                end
            end
            StData: begin
                if (pop) begin
                    data_d = {data_q[23:0], r_data};
                    cnt_d  = cnt_q - 2'd1;
                    if (cnt_q == 2'd0) state_d = StCsum;
                end
            end
            StCsum: begin
                if (pop) begin
                    csum_d  = r_data;
                    state_d = StExec;
                end
            end
            StExec: begin
                reply_d = NAK_BYTE;
                state_d = StResp;
                if (csum_q == frame_csum(cmd_q, data_q)) begin
                    case (cmd_q)
                        CMD_FTW: begin
                            ftw_d     = data_q;
                            ftw_upd_d = 1'b1;
                            reply_d   = ACK_BYTE;
                        end
                        CMD_WAVE: begin
                            wave_d  = data_q[1:0];
                            reply_d = ACK_BYTE;
                        end
                        CMD_AMP: begin
                            amp_d   = data_q[7:0];
                            reply_d = ACK_BYTE;
                        end
                        default: reply_d = NAK_BYTE;
                    endcase
                end
            end
            StResp: begin
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (timeout_hit) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            csum_q      <= '0;
            reply_q     <= '0;
            ftw_q       <= FTW_RST;
            ftw_upd_q   <= 1'b0;
            wave_q      <= '0;
            amp_q       <= 8'hFF;
            pop_block_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            reply_q     <= reply_d;
            ftw_q       <= ftw_d;
            ftw_upd_q   <= ftw_upd_d;
            wave_q      <= wave_d;
            amp_q       <= amp_d;
            pop_block_q <= pop;
        end
    end

    assign w_data      = reply_q;
    assign ftw         = ftw_q;
    assign ftw_upd     = ftw_upd_q;
    assign wave_sel    = wave_q;
    assign amp         = amp_q;
    assign timeout_err = timeout_hit;

endmodule
